parity_frame_checker: RTL

- Downstream consumer of the 16-input parity tree: takes 16-bit data words and their transmitted parity bits, recomputes word parity, and flags each mismatch.
- Groups words into fixed-length frames delimited by a start-of-frame flag.
- Emits one status record per frame over a valid/ready handshake, and keeps a sticky error flag for the control plane.

---
 rtl/parity_pkg.sv | 37 +++
 rtl/parity_frame_checker_if.sv | 48 ++++
 rtl/parity_word_calc.sv | 19 +
 rtl/parity_frame_checker.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
// ---------------------------------------------------------------------------
// parity_pkg
// Shared definitions for the parity frame checker slice:
//   - default word width, frame length and counter width
//   - frame-tracking state encoding
//   - saturating increment helper used by the error and abort counters
// ---------------------------------------------------------------------------
package parity_pkg;

  localparam int DATA_W_DEF    = 16;
  localparam int FRAME_LEN_DEF = 8;
  localparam int CNT_W_DEF     = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    REPORT = 2'd2
  } state_e;

  // Adds inc (0 or 1) to v, clamping at the largest value a w-bit counter
  // can hold. Operates on 32-bit containers so callers of any width <= 32
  // can share it.
  function automatic logic [31:0] sat_inc(input logic [31:0] v,
                                          input logic        inc,
                                          input int unsigned w);
    logic [32:0] max_v;
    max_v = (33'd1 << w) - 33'd1;
    if (!inc) begin
      return v;
    end
    if ({1'b0, v} >= max_v) begin
      return max_v[31:0];
    end
    return v + 32'd1;
  endfunction

endpackage

// File: rtl/parity_frame_checker_if.sv
// ---------------------------------------------------------------------------
// parity_frame_checker_if
// Word input stream and per-frame status stream of the parity frame checker.
//   in_valid/in_ready  : word handshake, in_data/in_par/in_sof qualify it
//   st_valid/st_ready  : status handshake, st_err_cnt is the payload
// Modports:
//   slave  - the checker (consumes words, produces status)
//   master - the environment (produces words, consumes status)
// ---------------------------------------------------------------------------
interface parity_frame_checker_if
  import parity_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_par;
  logic              in_sof;
  logic              st_valid;
  logic              st_ready;
  logic [CNT_W-1:0]  st_err_cnt;

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_par,
    input  in_sof,
    input  st_ready,
    output in_ready,
    output st_valid,
    output st_err_cnt
  );

  modport master (
    output in_valid,
    output in_data,
    output in_par,
    output in_sof,
    output st_ready,
    input  in_ready,
    input  st_valid,
    input  st_err_cnt
  );

endinterface

// File: rtl/parity_word_calc.sv
// ---------------------------------------------------------------------------
// parity_word_calc
// Combinational even-parity check of one word. Same reduction as the
// upstream parity tree so both ends agree bit-for-bit.
//   data : DATA_W-bit word
//   par  : transmitted parity bit
//   mism : 1 when XOR(data) ^ par != 0
// ---------------------------------------------------------------------------
module parity_word_calc #(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] data,
  input  logic              par,
  output logic              mism
);

  assign mism = (^data) ^ par;

endmodule

// File: rtl/parity_frame_checker.sv
// ---------------------------------------------------------------------------
// parity_frame_checker
// Checks transmitted parity of each accepted word, groups words into
// FRAME_LEN-word frames started by in_sof, and reports the number of
// mismatching words per completed frame on the status handshake.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   bus         : word input and status output streams (slave modport)
//   word_err    : one-cycle pulse, previous counted word had a mismatch
//   abort_cnt   : frames abandoned by an early SOF (saturating)
//   sticky_err  : set on any accepted mismatching word, cleared by clr_sticky
//   clr_sticky  : synchronous clear of sticky_err (a same-cycle set wins)
// ---------------------------------------------------------------------------
module parity_frame_checker
  import parity_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  parity_frame_checker_if.slave   bus,
  output logic                    word_err,
  output logic [CNT_W-1:0]        abort_cnt,
  output logic                    sticky_err,
  input  logic                    clr_sticky
);

  localparam int WCNT_W = $clog2(FRAME_LEN + 1);
  localparam logic [WCNT_W-1:0] LAST_IDX = WCNT_W'(FRAME_LEN - 1);
  localparam logic [WCNT_W-1:0] ONE_IDX  = WCNT_W'(1);

  state_e            state_q, state_d;
  logic [WCNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  abort_q, abort_d;
  logic              word_err_q, word_err_d;
  logic              sticky_q, sticky_d;

  logic              accept;
  logic              mism;
  logic              frame_done;
  logic [CNT_W-1:0]  mism_ext;

  parity_word_calc #(
    .DATA_W (DATA_W)
  ) u_word_calc (
    .data (bus.in_data),
    .par  (bus.in_par),
    .mism (mism)
  );

  // in_ready depends only on state_q, so accept has no loop through it.
  assign accept     = bus.in_valid & bus.in_ready;
  assign mism_ext   = {{(CNT_W-1){1'b0}}, mism};
  // Only a non-SOF word can close a frame; an SOF always restarts at count 1.
  assign frame_done = (state_q == RUN) & accept & ~bus.in_sof & (cnt_q == LAST_IDX);

  // State register and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      abort_q    <= '0;
      word_err_q <= 1'b0;
      sticky_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      abort_q    <= abort_d;
      word_err_q <= word_err_d;
      sticky_q   <= sticky_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept && bus.in_sof) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (frame_done) begin
          state_d = REPORT;
        end
      end
      REPORT: begin
        if (bus.st_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Counter / accumulator updates
  always_comb begin
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    abort_d    = abort_q;
    word_err_d = 1'b0;

    case (state_q)
      IDLE: begin
        // Non-SOF words in IDLE are dropped without counting.
        if (accept && bus.in_sof) begin
          cnt_d      = ONE_IDX;
          acc_d      = mism_ext;
          word_err_d = mism;
        end
      end
      RUN: begin
        if (accept) begin
          word_err_d = mism;
          if (bus.in_sof) begin
            abort_d = CNT_W'(sat_inc(32'(abort_q), 1'b1, CNT_W));
            cnt_d   = ONE_IDX;
            acc_d   = mism_ext;
          end else begin
            cnt_d = frame_done ? '0 : cnt_q + ONE_IDX;
            acc_d = CNT_W'(sat_inc(32'(acc_q), mism, CNT_W));
          end
        end
      end
      REPORT: begin
        // acc_q is the reported count; it stays put until the handshake.
        if (bus.st_ready) begin
          acc_d = '0;
        end
      end
      default: begin
        cnt_d = '0;
        acc_d = '0;
      end
    endcase

    // Dropped IDLE words still set the sticky flag; set beats clear.
    if (accept && mism) begin
      sticky_d = 1'b1;
    end else if (clr_sticky) begin
      sticky_d = 1'b0;
    end else begin
      sticky_d = sticky_q;
    end
  end

  // Outputs
  always_comb begin
    bus.in_ready   = (state_q != REPORT);
    bus.st_valid   = (state_q == REPORT);
    bus.st_err_cnt = (state_q == REPORT) ? acc_q : '0;
    word_err       = word_err_q;
    abort_cnt      = abort_q;
    sticky_err     = sticky_q;
  end

endmodule
